// File: rtl/fd_csr_responder.sv
// Wishbone CSR slave for one fine-delay core: RSTR/IDR/SCR/CMDR control words.
// Optional macro FD_CSR_ERR_EN adds wb_err_o for bad RSTR keys and IDR writes.
module fd_csr_responder #(
  parameter logic [31:0] g_id          = 32'hF19EDE1A,
  parameter int          g_ack_latency = 1,
  parameter logic [15:0] g_rstr_key    = 16'hDEAD
) (
  input  logic        clk_sys_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
`ifdef FD_CSR_ERR_EN
  output logic        wb_err_o,
`endif
  output logic        rst_core_n_o,
  output logic        rst_fmc_n_o,
  output logic [3:0]  cmd_pulse_o,
  input  logic        busy_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  localparam logic [1:0] ADR_RSTR = 2'd0;
  localparam logic [1:0] ADR_IDR  = 2'd1;
  localparam logic [1:0] ADR_SCR  = 2'd2;
  localparam logic [1:0] ADR_CMDR = 2'd3;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [1:0]  r_adr;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_dat;
  logic [31:0] r_scr;
  logic        r_rst_core_n;
  logic        r_rst_fmc_n;
  logic [3:0]  r_cmd;

  logic        w_key_ok;
  logic        w_rstr_ok;
  logic        w_err;
  logic        w_in_ack;
  logic [31:0] w_rdata;

  assign w_key_ok  = (r_dat[31:16] == g_rstr_key);
  assign w_rstr_ok = w_key_ok && (r_sel == 4'hF);
  assign w_in_ack  = (r_state == ST_ACK);

`ifdef FD_CSR_ERR_EN
  assign w_err    = r_we && (((r_adr == ADR_RSTR) && !w_key_ok) || (r_adr == ADR_IDR));
  assign wb_err_o = w_in_ack && w_err;
`else
  assign w_err    = 1'b0;
`endif

  assign wb_ack_o     = w_in_ack && !w_err;
  assign wb_stall_o   = (r_state != ST_IDLE);
  assign rst_core_n_o = r_rst_core_n;
  assign rst_fmc_n_o  = r_rst_fmc_n;
  assign cmd_pulse_o  = r_cmd;

  // busy_i is read live so the value returned is the one seen in the ACK cycle.
  always_comb begin
    w_rdata = 32'h0;
    case (r_adr)
      ADR_RSTR: w_rdata = {30'h0, r_rst_core_n, r_rst_fmc_n};
      ADR_IDR:  w_rdata = g_id;
      ADR_SCR:  w_rdata = r_scr;
      ADR_CMDR: w_rdata = {31'h0, busy_i};
      default:  w_rdata = 32'h0;
    endcase
  end

  assign wb_dat_o = (w_in_ack && !r_we) ? w_rdata : 32'h0;

  // Side effects commit on the edge that leaves ACK, so they appear the cycle after ack.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 3'd0;
      r_adr        <= 2'd0;
      r_we         <= 1'b0;
      r_sel        <= 4'h0;
      r_dat        <= 32'h0;
      r_scr        <= 32'h0;
      r_rst_core_n <= 1'b0;
      r_rst_fmc_n  <= 1'b0;
      r_cmd        <= 4'h0;
    end else begin
      r_cmd <= 4'h0;
      case (r_state)
        ST_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            r_adr <= wb_adr_i;
            r_we  <= wb_we_i;
            r_sel <= wb_sel_i;
            r_dat <= wb_dat_i;
            if (g_ack_latency <= 1) begin
              r_state <= ST_ACK;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= 3'(g_ack_latency - 1);
            end
          end
        end
        ST_WAIT: begin
          if (!wb_cyc_i) begin
            r_state <= ST_IDLE;
          end else if (r_cnt <= 3'd1) begin
            r_state <= ST_ACK;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          if (r_we && !w_err) begin
            case (r_adr)
              ADR_RSTR: begin
                if (w_rstr_ok) begin
                  r_rst_fmc_n  <= r_dat[0];
                  r_rst_core_n <= r_dat[1];
                end
              end
              ADR_SCR: begin
                for (int b = 0; b < 4; b++) begin
                  if (r_sel[b]) r_scr[b*8 +: 8] <= r_dat[b*8 +: 8];
                end
              end
              ADR_CMDR: r_cmd <= r_dat[3:0] & {4{r_sel[0]}};
              default: ;
            endcase
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fd_csr_responder.sv
// Self-checking bench for fd_csr_responder: a latency-1 and a latency-4 instance.
// Expected read data is queued per instance and popped when ack/err appears.
module tb_fd_csr_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        cyc   [2];
  logic        stb   [2];
  logic        we    [2];
  logic [1:0]  adr   [2];
  logic [3:0]  sel   [2];
  logic [31:0] dati  [2];
  logic [31:0] dato  [2];
  logic        ack   [2];
  logic        stall [2];
  logic        err   [2];
  logic        coreN [2];
  logic        fmcN  [2];
  logic [3:0]  cmd   [2];
  logic        busy  [2];

`ifdef FD_CSR_ERR_EN
  localparam logic ERRV = 1'b1;
`else
  localparam logic ERRV = 1'b0;
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
`endif

  fd_csr_responder #(.g_ack_latency(1)) dut0 (
    .clk_sys_i(clk), .rst_i(rst[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
    .wb_we_i(we[0]), .wb_adr_i(adr[0]), .wb_sel_i(sel[0]), .wb_dat_i(dati[0]),
    .wb_dat_o(dato[0]), .wb_ack_o(ack[0]), .wb_stall_o(stall[0]),
`ifdef FD_CSR_ERR_EN
    .wb_err_o(err[0]),
`endif
    .rst_core_n_o(coreN[0]), .rst_fmc_n_o(fmcN[0]), .cmd_pulse_o(cmd[0]),
    .busy_i(busy[0])
  );

  fd_csr_responder #(.g_ack_latency(4)) dut1 (
    .clk_sys_i(clk), .rst_i(rst[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
    .wb_we_i(we[1]), .wb_adr_i(adr[1]), .wb_sel_i(sel[1]), .wb_dat_i(dati[1]),
    .wb_dat_o(dato[1]), .wb_ack_o(ack[1]), .wb_stall_o(stall[1]),
`ifdef FD_CSR_ERR_EN
    .wb_err_o(err[1]),
`endif
    .rst_core_n_o(coreN[1]), .rst_fmc_n_o(fmcN[1]), .cmd_pulse_o(cmd[1]),
    .busy_i(busy[1])
  );

  typedef struct {
    logic [31:0] data;
    logic        isErr;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] rdata;
    logic        isErr;
    logic [1:0]  rstN;
    logic [3:0]  cmd;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;
  int   ackCount [2];
  int   lat [2];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expectation per ack/err, and requires idle data to be zero.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ack[d] || err[d]) begin
        exp_t e;
        if (ack[d]) ackCount[d]++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          checkOutput(d == 0 ? "unexpected_ack0" : "unexpected_ack1", 32'd1, 32'd0);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          checkOutput("ack_err_kind", {30'h0, err[d], ack[d]}, e.isErr ? 32'd2 : 32'd1);
          checkOutput("rdata", dato[d], e.data);
        end
      end else if (dato[d] !== 32'h0) begin
        checkOutput("idle_data_zero", dato[d], 32'h0);
      end
    end
  end

  task automatic pushExp(input int d, input logic [31:0] data, input logic isErr);
    exp_t e;
    e.data  = data;
    e.isErr = isErr;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // One non-pipelined access; returns at the cycle after ack/err, when side effects are visible.
  task automatic applyStimulus(input int d, input logic w, input logic [1:0] a, input logic [3:0] s,
                               input logic [31:0] dat, input logic [31:0] expData, input logic expErr);
    int n;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; dati[d] = dat;
    pushExp(d, expData, expErr);
    @(posedge clk); #1;
    stb[d] = 1'b0;
    n = 1;
    while (!(ack[d] || err[d]) && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("latency", 32'(n), 32'(lat[d]));
    checkOutput("cmd_zero_in_ack", {28'h0, cmd[d]}, 32'h0);
    @(negedge clk);
    cyc[d] = 1'b0; we[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t vecs [20];

  initial begin
    lat[0] = 1; lat[1] = 4;
    ackCount[0] = 0; ackCount[1] = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      adr[d] = 2'd0; sel[d] = 4'h0; dati[d] = 32'h0; busy[d] = 1'b0;
    end

    vecs[0]  = '{1'b0, 2'd1, 4'hF, 32'h0,        32'hF19EDE1A, 1'b0, 2'b00, 4'h0};
    vecs[1]  = '{1'b0, 2'd0, 4'hF, 32'h0,        32'h00000000, 1'b0, 2'b00, 4'h0};
    vecs[2]  = '{1'b0, 2'd2, 4'hF, 32'h0,        32'h00000000, 1'b0, 2'b00, 4'h0};
    vecs[3]  = '{1'b1, 2'd0, 4'hF, 32'hDEADFFFF, 32'h0,        1'b0, 2'b11, 4'h0};
    vecs[4]  = '{1'b0, 2'd0, 4'hF, 32'h0,        32'h00000003, 1'b0, 2'b11, 4'h0};
    vecs[5]  = '{1'b1, 2'd0, 4'hF, 32'hBEEF0000, 32'h0,        ERRV, 2'b11, 4'h0};
    vecs[6]  = '{1'b1, 2'd0, 4'h7, 32'hDEAD0000, 32'h0,        1'b0, 2'b11, 4'h0};
    vecs[7]  = '{1'b1, 2'd1, 4'hF, 32'h12345678, 32'h0,        ERRV, 2'b11, 4'h0};
    vecs[8]  = '{1'b0, 2'd1, 4'hF, 32'h0,        32'hF19EDE1A, 1'b0, 2'b11, 4'h0};
    vecs[9]  = '{1'b1, 2'd2, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 2'b11, 4'h0};
    vecs[10] = '{1'b1, 2'd2, 4'h2, 32'h00000000, 32'h0,        1'b0, 2'b11, 4'h0};
    vecs[11] = '{1'b0, 2'd2, 4'hF, 32'h0,        32'hDEAD00EF, 1'b0, 2'b11, 4'h0};
    vecs[12] = '{1'b1, 2'd2, 4'h8, 32'h12345678, 32'h0,        1'b0, 2'b11, 4'h0};
    vecs[13] = '{1'b0, 2'd2, 4'hF, 32'h0,        32'h12AD00EF, 1'b0, 2'b11, 4'h0};
    vecs[14] = '{1'b1, 2'd0, 4'hF, 32'hDEAD0001, 32'h0,        1'b0, 2'b01, 4'h0};
    vecs[15] = '{1'b0, 2'd0, 4'hF, 32'h0,        32'h00000001, 1'b0, 2'b01, 4'h0};
    vecs[16] = '{1'b1, 2'd3, 4'h1, 32'h0000000A, 32'h0,        1'b0, 2'b01, 4'hA};
    vecs[17] = '{1'b1, 2'd3, 4'h2, 32'h0000000F, 32'h0,        1'b0, 2'b01, 4'h0};
    vecs[18] = '{1'b0, 2'd3, 4'hF, 32'h0,        32'h00000000, 1'b0, 2'b01, 4'h0};
    vecs[19] = '{1'b1, 2'd0, 4'hF, 32'hDEADFFFF, 32'h0,        1'b0, 2'b11, 4'h0};

    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset_ack",   {31'h0, ack[d]},   32'h0);
      checkOutput("reset_stall", {31'h0, stall[d]}, 32'h0);
      checkOutput("reset_rstN",  {30'h0, coreN[d], fmcN[d]}, 32'h0);
      checkOutput("reset_cmd",   {28'h0, cmd[d]},   32'h0);
    end

    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, vecs[i].rdata, vecs[i].isErr);
      checkOutput($sformatf("vec%0d_rstN", i), {30'h0, coreN[0], fmcN[0]}, {30'h0, vecs[i].rstN});
      checkOutput($sformatf("vec%0d_cmd", i),  {28'h0, cmd[0]}, {28'h0, vecs[i].cmd});
    end

    // Back-to-back CMDR writes give two separate one-cycle pulses.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 1'b1, 2'd3, 4'hF, 32'h5, 32'h0, 1'b0);
      checkOutput("cmd_pulse_b2b", {28'h0, cmd[0]}, 32'h5);
    end
    @(posedge clk); #1;
    checkOutput("cmd_pulse_gone", {28'h0, cmd[0]}, 32'h0);

    busy[0] = 1'b1;
    applyStimulus(0, 1'b0, 2'd3, 4'hF, 32'h0, 32'h1, 1'b0);
    busy[0] = 1'b0;

    // Latency-4 instance: seed SCR, then abandon a write mid-WAIT by dropping cyc.
    applyStimulus(1, 1'b1, 2'd2, 4'hF, 32'hAAAA5555, 32'h0, 1'b0);
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 2'd2; sel[1] = 4'hF; dati[1] = 32'h0;
    @(posedge clk); #1;
    stb[1] = 1'b0;
    checkOutput("stall_in_wait", {31'h0, stall[1]}, 32'h1);
    @(negedge clk);
    cyc[1] = 1'b0;
    @(posedge clk); #1;
    checkOutput("stall_after_drop", {31'h0, stall[1]}, 32'h0);
    repeat (6) @(posedge clk);
    applyStimulus(1, 1'b0, 2'd2, 4'hF, 32'h0, 32'hAAAA5555, 1'b0);

    // Reset during WAIT drops the access and returns to idle.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 2'd2; sel[1] = 4'hF; dati[1] = 32'h12341234;
    @(posedge clk); #1;
    stb[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_wait_stall", {31'h0, stall[1]}, 32'h0);
    checkOutput("rst_wait_ack",   {31'h0, ack[1]},   32'h0);
    @(negedge clk);
    rst[1] = 1'b0; cyc[1] = 1'b0; we[1] = 1'b0;
    repeat (6) @(posedge clk);
    applyStimulus(1, 1'b0, 2'd2, 4'hF, 32'h0, 32'h0, 1'b0);
    checkOutput("rst_wait_coreN", {31'h0, coreN[1]}, 32'h0);

    // Pipelined burst of 4 strobes held against stall on the latency-1 instance.
    begin
      logic        bwe  [4];
      logic [31:0] bdat [4];
      logic [31:0] bexp [4];
      int k, guard, acks0;
      logic stallBefore;
      bwe[0] = 1'b1; bdat[0] = 32'h11111111; bexp[0] = 32'h0;
      bwe[1] = 1'b0; bdat[1] = 32'h0;        bexp[1] = 32'h11111111;
      bwe[2] = 1'b1; bdat[2] = 32'h22222222; bexp[2] = 32'h0;
      bwe[3] = 1'b0; bdat[3] = 32'h0;        bexp[3] = 32'h22222222;
      acks0 = ackCount[0];
      k = 0; guard = 0;
      @(negedge clk);
      cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 2'd2; sel[0] = 4'hF;
      we[0] = bwe[0]; dati[0] = bdat[0];
      pushExp(0, bexp[0], 1'b0);
      while (k < 4 && guard < 40) begin
        stallBefore = stall[0];
        @(posedge clk); #1;
        guard++;
        if (!stallBefore) begin
          k++;
          if (k < 4) begin
            we[0] = bwe[k]; dati[0] = bdat[k];
            pushExp(0, bexp[k], 1'b0);
          end else begin
            stb[0] = 1'b0;
          end
        end
        @(negedge clk);
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      cyc[0] = 1'b0; we[0] = 1'b0;
      @(posedge clk); #1;
      checkOutput("burst_accepts", 32'(k), 32'd4);
      checkOutput("burst_acks", 32'(ackCount[0] - acks0), 32'd4);
    end

    repeat (2) @(posedge clk);
    checkOutput("q0_drained", 32'(q0.size()), 32'd0);
    checkOutput("q1_drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fd_csr_responder.md
Name: fd_csr_responder

Overview:
- Wishbone classic/pipelined slave that answers the register accesses a host bus initiator issues to one fine-delay core.
- Implements the core's top control words: unlock-keyed reset register (RSTR), ID register (IDR), scratch register (SCR) and command register (CMDR).
- Sits behind the VME-to-Wishbone bridge and crossbar, one instance per FMC slot, and drives the core's soft resets and command strobe.

Parameters:
- g_id, 32'hF19EDE1A, constant returned by IDR.
- g_ack_latency, 1, cycles from request accept to ack; legal range 1..4.
- g_rstr_key, 16'hDEAD, unlock key required in RSTR write bits [31:16].

Ports:
- clk_sys_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  2  word address: 0=RSTR, 1=IDR, 2=SCR, 3=CMDR.
- wb_sel_i  in  4  byte selects.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- wb_stall_o  out  1  stall.
- rst_core_n_o  out  1  core soft reset, active-low.
- rst_fmc_n_o  out  1  FMC soft reset, active-low.
- cmd_pulse_o  out  4  one-cycle command strobes.
- busy_i  in  1  core busy status, readable in CMDR.

Behaviour:
- Reset values (rst_i high at a clk_sys_i edge):
  - wb_ack_o=0, wb_stall_o=0, wb_dat_o=0.
  - rst_core_n_o=0, rst_fmc_n_o=0 (core held in reset until software releases it).
  - SCR=0, cmd_pulse_o=0.
  - FSM returns to IDLE.
- Reset mid-transaction: the pending access is dropped, no ack, no side effect.
- FSM states IDLE, WAIT, ACK:
  - IDLE: when cyc&stb, latch adr, we, sel, dat_i. If g_ack_latency=1 go to ACK, else go to WAIT with counter=g_ack_latency-1.
  - WAIT: decrement counter; at 1 go to ACK.
  - ACK: wb_ack_o=1 for exactly one cycle; commit write side effects and drive wb_dat_o this cycle; next state IDLE.
- wb_stall_o=1 in WAIT and ACK, 0 in IDLE. Exactly one ack per accepted strobe.
- cyc drops while in WAIT: return to IDLE, no ack, no side effect.
- Latency: ack asserted g_ack_latency cycles after the accept edge.
- Register semantics:
  - RSTR write: accepted only if dat[31:16]==g_rstr_key and sel==4'hF. On accept, bit0 goes to rst_fmc_n_o and bit1 to rst_core_n_o, registered at the ACK edge. Wrong key or partial sel is ignored, but still acked.
  - RSTR read: {16'h0, 14'h0, rst_core_n_o, rst_fmc_n_o}.
  - IDR read: g_id. IDR write is ignored and acked.
  - SCR: read/write. Writes are byte-masked by sel.
  - CMDR write: cmd_pulse_o[3:0] = dat[3:0]&{4{sel[0]}} for exactly the cycle after ACK, then returns to 0. Back-to-back writes produce separate pulses.
  - CMDR read: {31'h0, busy_i}, where busy_i is sampled in the ACK cycle.
- wb_dat_o is 0 on every cycle except ACK of a read.
- Reads have no side effects.

Optional Feature:
- FD_CSR_ERR_EN, compiled in:
  - Adds output wb_err_o (1 bit, reset 0).
  - An RSTR write with a wrong key asserts wb_err_o instead of wb_ack_o in the ACK cycle, for one cycle; outputs are unchanged.
  - An IDR write also errors.
  - The stall and latency rules are unchanged.
- Compiled out: no wb_err_o port; both cases ack silently.

Test Plan:
- Reset, then read adr 1 -> ack exactly g_ack_latency cycles after accept, wb_dat_o=32'hF19EDE1A. Both soft-reset outputs are 0 before any write.
- Write RSTR 32'hDEADFFFF -> rst_core_n_o=1 and rst_fmc_n_o=1 after ack. Then write 32'hBEEF0000 -> both outputs stay 1; with FD_CSR_ERR_EN, wb_err_o pulses and no ack.
- SCR write 32'hDEADBEEF sel=4'hF, then write 32'h00000000 sel=4'b0010 -> read returns 32'hDEAD00EF.
- CMDR write 32'h5 twice back-to-back -> cmd_pulse_o=4'h5 for one cycle after each ack (two distinct pulses). With busy_i=1, CMDR read -> 32'h1.
- g_ack_latency=4, drop cyc in WAIT during an SCR write -> no ack, SCR unchanged. Assert rst_i in WAIT -> next cycle IDLE, stall=0, no ack.
- Pipelined burst of 4 strobes -> stall holds off each subsequent strobe; exactly 4 acks, with data in order.
